// File: rtl/interface_name_responder_rtl_pkg.sv
// interface_name_pkg_hdl: shared responder FSM states, request record and default bus widths
package interface_name_pkg_hdl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} responder_state_t;
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } responder_req_t;
endpackage

// File: rtl/interface_name_responder_rtl_if.sv
// interface_name_if: request (valid/ready/write/addr/wdata) and response (valid/ready/rdata/error) channels; master drives requests, slave drives responses
interface interface_name_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;
  modport master (output req_valid, req_write, req_addr, req_wdata, rsp_ready,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_error);
  modport slave  (input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
                  output req_ready, rsp_valid, rsp_rdata, rsp_error);
endinterface

// File: rtl/interface_name_responder_rtl_mem.sv
// interface_name_responder_mem: DEPTH x DATA_WIDTH array; ports clock_i, reset_ni (sync clear), we_i/addr_i/wdata_i (sync write), rdata_o (async read of addr_i)
module interface_name_responder_mem #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  parameter int IW         = 6
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic                  we_i,
  input  logic [IW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/interface_name_responder_rtl.sv
// interface_name_responder_rtl: one-at-a-time memory responder; ports clock_i, reset_ni (sync active-low), bus (interface_name_if.slave)
module interface_name_responder_rtl
  import interface_name_pkg_hdl::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int DEPTH      = 64,
  parameter int LATENCY    = 2
) (
  input  logic            clock_i,
  input  logic            reset_ni,
  interface_name_if.slave bus
);
  localparam int CW = LATENCY > 0 ? $clog2(LATENCY + 1) : 1;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  responder_state_t      state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;
  logic                  accept, in_range, cur_write, enter;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  assign bus.req_ready = reset_ni && state_q == IDLE;
  assign accept        = bus.req_valid && bus.req_ready;
  // In IDLE the live request is the one being serviced (needed when LATENCY==0 enters RESP at the accept edge)
  assign cur_addr      = state_q == IDLE ? bus.req_addr : addr_q;
  assign cur_write     = state_q == IDLE ? bus.req_write : write_q;
  assign in_range      = 32'(cur_addr) < DEPTH;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;
  interface_name_responder_mem #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .IW(IW)) u_mem (
    .clock_i (clock_i),
    .reset_ni(reset_ni),
    .we_i    (accept && bus.req_write && in_range),
    .addr_i  (cur_addr[IW-1:0]),
    .wdata_i (bus.req_wdata),
    .rdata_o (mem_rdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: if (accept) begin
        write_d = bus.req_write;
        addr_d  = bus.req_addr;
        cnt_d   = CW'(LATENCY);
        state_d = LATENCY == 0 ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? RESP : WAIT;
      end
      RESP: state_d = bus.rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    enter       = state_d == RESP && state_q != RESP;
    rsp_valid_d = state_d == RESP;
    rsp_error_d = enter ? !in_range : rsp_valid_d && rsp_error_q;
    rsp_rdata_d = enter ? (!cur_write && in_range ? mem_rdata : '0) : rsp_valid_d ? rsp_rdata_q : '0;
  end
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end
endmodule

// File: tb/tb_interface_name_responder_rtl.sv
// tb_interface_name_responder_rtl: scoreboard bench for LATENCY=2 and LATENCY=0 responder builds
module tb_interface_name_responder_rtl;
  typedef struct packed {logic err; logic [31:0] rd;} exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  logic [31:0] mem_m [2][64];
  logic req_valid [2], req_write [2], rsp_ready [2];
  logic [7:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic rdy_o [2], vld_o [2], err_o [2];
  logic [31:0] rdata_o [2];
  always #5 clk = ~clk;
  interface_name_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) a ();
  interface_name_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) b ();
  assign a.req_valid = req_valid[0];
  assign a.req_write = req_write[0];
  assign a.req_addr  = req_addr[0];
  assign a.req_wdata = req_wdata[0];
  assign a.rsp_ready = rsp_ready[0];
  assign b.req_valid = req_valid[1];
  assign b.req_write = req_write[1];
  assign b.req_addr  = req_addr[1];
  assign b.req_wdata = req_wdata[1];
  assign b.rsp_ready = rsp_ready[1];
  assign rdy_o[0] = a.req_ready;
  assign vld_o[0] = a.rsp_valid;
  assign err_o[0] = a.rsp_error;
  assign rdata_o[0] = a.rsp_rdata;
  assign rdy_o[1] = b.req_ready;
  assign vld_o[1] = b.rsp_valid;
  assign err_o[1] = b.rsp_error;
  assign rdata_o[1] = b.rsp_rdata;
  interface_name_responder_rtl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .LATENCY(2)) u_dut2 (
    .clock_i(clk), .reset_ni(reset_n), .bus(a));
  interface_name_responder_rtl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .LATENCY(0)) u_dut0 (
    .clock_i(clk), .reset_ni(reset_n), .bus(b));
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) mem_m[d][i] = '0;
    sb.delete();
  endtask
  task automatic txn(int d, bit w, logic [7:0] ad, logic [31:0] wd, int stall);
    int k;
    exp_t e;
    logic [31:0] held;
    k = 0;
    while (!rdy_o[d] && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_idle", 64'(rdy_o[d]), 64'd1);
    req_valid[d] = 1'b1;
    req_write[d] = w;
    req_addr[d]  = ad;
    req_wdata[d] = wd;
    rsp_ready[d] = 1'b0;
    e.err = ad >= 8'd64;
    e.rd  = (!w && ad < 8'd64) ? mem_m[d][ad[5:0]] : 32'h0;
    if (w && ad < 8'd64) mem_m[d][ad[5:0]] = wd;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!vld_o[d] && k < 20);
    check("rsp_latency", 64'(k), d == 0 ? 64'd3 : 64'd1);
    held = rdata_o[d];
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("backpressure_hold", {vld_o[d], rdata_o[d], rdy_o[d]}, {1'b1, held, 1'b0});
    end
    rsp_ready[d] = 1'b1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rsp_rdata", 64'(rdata_o[d]), 64'(e.rd));
      check("rsp_error", 64'(err_o[d]), 64'(e.err));
    end else check("scoreboard_empty", 64'd0, 64'd1);
    @(posedge clk);
    #1 rsp_ready[d] = 1'b0;
    @(negedge clk);
    check("post_handshake", {vld_o[d], rdy_o[d]}, 64'b01);
  endtask
  initial begin
    int acc;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      rsp_ready[d] = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
    end
    clear_model();
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 8'h05;
    req_wdata[0] = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_req_ready", {rdy_o[0], rdy_o[1]}, 64'b00);
      check("reset_rsp_valid", {vld_o[0], vld_o[1]}, 64'b00);
    end
    reset_n = 1'b1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    txn(0, 1'b0, 8'h05, 32'h0, 0);
    txn(0, 1'b1, 8'h05, 32'hDEADBEEF, 0);
    txn(0, 1'b0, 8'h05, 32'h0, 0);
    txn(0, 1'b0, 8'h40, 32'h0, 0);
    txn(0, 1'b1, 8'h40, 32'hCAFEF00D, 0);
    txn(0, 1'b0, 8'h00, 32'h0, 0);
    txn(0, 1'b0, 8'hFF, 32'h0, 0);
    txn(0, 1'b1, 8'h3F, 32'h0BADF00D, 0);
    txn(0, 1'b0, 8'h3F, 32'h0, 0);
    txn(0, 1'b0, 8'h05, 32'h0, 5);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 8'h03;
    req_wdata[0] = 32'hA5A5A5A5;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    clear_model();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abandoned_no_rsp", 64'(vld_o[0]), 64'd0);
    end
    txn(0, 1'b0, 8'h03, 32'h0, 0);
    txn(0, 1'b0, 8'h05, 32'h0, 0);
    txn(1, 1'b1, 8'h10, 32'h11112222, 0);
    txn(1, 1'b0, 8'h10, 32'h0, 0);
    txn(1, 1'b0, 8'h40, 32'h0, 2);
    rsp_ready[1] = 1'b1;
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 8'h08;
    req_wdata[1] = 32'h00000077;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rdy_o[1]) acc++;
      check("b2b_alternate", {vld_o[1], rdy_o[1]}, (i % 2 == 0) ? 64'b10 : 64'b01);
    end
    req_valid[1] = 1'b0;
    check("b2b_accepts", 64'(acc), 64'd4);
    mem_m[1][8] = 32'h00000077;
    @(negedge clk);
    rsp_ready[1] = 1'b0;
    txn(1, 1'b0, 8'h08, 32'h0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
